// File: rtl/mux_arbiter.sv
// Registered M-to-1 arbitrating multiplexer with valid/ready on every channel.
// Define MUX_ARB_ROUND_ROBIN_EN for round-robin arbitration; otherwise the lowest valid index wins.
module mux_arbiter #(
  parameter int N = 32,
  parameter int M = 4,
  localparam int S = $clog2(M)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [M*N-1:0] in_data,
  input  logic [M-1:0]   in_valid,
  output logic [M-1:0]   in_ready,
  output logic [N-1:0]   out_data,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [S-1:0]   out_sel
);

  logic           load;
  logic           gntValid;
  logic           inXfer;
  logic [S-1:0]   gntIdx;
  logic [S-1:0]   basePtr;
  logic [S:0]     scanIdx;

  logic [N-1:0]   outData_q, outData_d;
  logic [S-1:0]   outSel_q, outSel_d;
  logic           outValid_q, outValid_d;

  // Scan downward so the channel closest to basePtr (in wrapped order) is written last and wins.
  always_comb begin
    gntValid = 1'b0;
    gntIdx   = '0;
    scanIdx  = '0;
    for (int k = M - 1; k >= 0; k--) begin
      scanIdx = {1'b0, basePtr} + (S + 1)'(k);
      if (scanIdx >= (S + 1)'(M)) begin
        scanIdx = scanIdx - (S + 1)'(M);
      end
      if (in_valid[scanIdx[S-1:0]]) begin
        gntValid = 1'b1;
        gntIdx   = scanIdx[S-1:0];
      end
    end
  end

  assign load   = !rst && (!outValid_q || out_ready);
  assign inXfer = gntValid && load;

  always_comb begin
    in_ready = '0;
    if (inXfer) begin
      in_ready[gntIdx] = 1'b1;
    end
  end

  always_comb begin
    outData_d  = outData_q;
    outSel_d   = outSel_q;
    outValid_d = outValid_q;
    if (inXfer) begin
      outData_d  = in_data[int'(gntIdx)*N +: N];
      outSel_d   = gntIdx;
      outValid_d = 1'b1;
    end else if (outValid_q && out_ready) begin
      outValid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      outData_q  <= '0;
      outSel_q   <= '0;
      outValid_q <= 1'b0;
    end else begin
      outData_q  <= outData_d;
      outSel_q   <= outSel_d;
      outValid_q <= outValid_d;
    end
  end

`ifdef MUX_ARB_ROUND_ROBIN_EN
  logic [S-1:0] ptr_q, ptr_d;
  logic [S-1:0] nextPtr;

  // Explicit wrap keeps the pointer inside 0..M-1 when M is not a power of two.
  assign nextPtr = (gntIdx == S'(M - 1)) ? '0 : gntIdx + 1'b1;
  assign ptr_d   = inXfer ? nextPtr : ptr_q;
  assign basePtr = ptr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`else
  assign basePtr = '0;
`endif

  assign out_data  = outData_q;
  assign out_sel   = outSel_q;
  assign out_valid = outValid_q;

endmodule

// File: tb/tb_mux_arbiter.sv
// Self-checking bench for mux_arbiter: hand-derived vector table plus a scoreboarded reference model.
// Expectations follow MUX_ARB_ROUND_ROBIN_EN when it is defined, fixed priority otherwise.
module tb_mux_arbiter;

  localparam int N = 32;
  localparam int M = 4;
  localparam int S = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic [M*N-1:0] in_data;
  logic [M-1:0]   in_valid;
  logic [M-1:0]   in_ready;
  logic [N-1:0]   out_data;
  logic           out_valid;
  logic           out_ready;
  logic [S-1:0]   out_sel;

  typedef struct {
    logic        rst;
    logic [3:0]  v;
    logic        r;
    logic [3:0]  expReady;
    logic        expValid;
    logic [31:0] expData;
    logic [1:0]  expSel;
  } vec_t;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  sel;
  } word_t;

  vec_t  vecs[$];
  word_t expQ[$];
  int    checks = 0;
  int    errors = 0;
  logic [1:0] mPtr;
  logic       mValid;

  always #5 clk = ~clk;

  mux_arbiter #(.N(N), .M(M)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sel   (out_sel)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic addVec(input logic r0, input logic [3:0] v, input logic r, input logic [3:0] er,
                        input logic ev, input logic [31:0] ed, input logic [1:0] es);
    vec_t t;
    t.rst = r0; t.v = v; t.r = r; t.expReady = er; t.expValid = ev; t.expData = ed; t.expSel = es;
    vecs.push_back(t);
  endtask

  // One cycle: drive at the falling edge, check in_ready before the rising edge, outputs after it.
  task automatic applyStimulus(input vec_t vv, input int idx);
    logic [3:0] mReady;
    logic       gnt;
    logic [1:0] g;
    logic       xfer;
    word_t      w;
    @(negedge clk);
    rst       = vv.rst;
    in_valid  = vv.v;
    out_ready = vv.r;
    #1;
    gnt = 1'b0;
    g   = 2'd0;
    for (int k = M - 1; k >= 0; k--) begin
      int j;
      j = (int'(mPtr) + k) % M;
      if (in_valid[j]) begin
        gnt = 1'b1;
        g   = 2'(j);
      end
    end
    mReady = (gnt && !rst && (!mValid || out_ready)) ? (4'b0001 << g) : 4'b0000;
    checkOutput($sformatf("vec%0d in_ready", idx), 32'(in_ready), 32'(vv.expReady));
    checkOutput($sformatf("sb%0d in_ready", idx), 32'(in_ready), 32'(mReady));
    xfer = (mReady != 4'b0000);
    if (xfer) begin
      w.data = 32'((int'(g) + 1) * (int'(g) + 1));
      w.sel  = g;
      expQ.push_back(w);
    end
    @(posedge clk);
    #1;
    if (rst) begin
      mValid = 1'b0;
      mPtr   = 2'd0;
      expQ.delete();
    end else if (xfer) begin
      mValid = 1'b1;
`ifdef MUX_ARB_ROUND_ROBIN_EN
      mPtr = (g == 2'(M - 1)) ? 2'd0 : g + 2'd1;
`endif
    end else if (mValid && out_ready) begin
      mValid = 1'b0;
    end
    checkOutput($sformatf("vec%0d out_valid", idx), 32'(out_valid), 32'(vv.expValid));
    checkOutput($sformatf("vec%0d out_data", idx), out_data, vv.expData);
    checkOutput($sformatf("vec%0d out_sel", idx), 32'(out_sel), 32'(vv.expSel));
    checkOutput($sformatf("sb%0d out_valid", idx), 32'(out_valid), 32'(mValid));
    if (xfer && !rst) begin
      if (expQ.size() == 0) begin
        checkOutput($sformatf("sb%0d queue empty", idx), 32'd1, 32'd0);
      end else begin
        w = expQ.pop_front();
        checkOutput($sformatf("sb%0d out_data", idx), out_data, w.data);
        checkOutput($sformatf("sb%0d out_sel", idx), 32'(out_sel), 32'(w.sel));
      end
    end
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = '0;
    out_ready = 1'b0;
    in_data   = {32'd16, 32'd9, 32'd4, 32'd1};
    mPtr      = 2'd0;
    mValid    = 1'b0;

    // Reset held with all channels requesting
    addVec(1, 4'b1111, 1, 4'b0000, 0, 0, 0);
    addVec(1, 4'b1111, 1, 4'b0000, 0, 0, 0);
    // Single channel, then drain with data and select held
    addVec(0, 4'b0100, 1, 4'b0100, 1, 9, 2);
    addVec(0, 4'b0000, 1, 4'b0000, 0, 9, 2);
    addVec(1, 4'b0000, 1, 4'b0000, 0, 0, 0);
`ifdef MUX_ARB_ROUND_ROBIN_EN
    // Saturated fairness then skip-and-wrap
    addVec(0, 4'b1111, 1, 4'b0001, 1, 1, 0);
    addVec(0, 4'b1111, 1, 4'b0010, 1, 4, 1);
    addVec(0, 4'b1111, 1, 4'b0100, 1, 9, 2);
    addVec(0, 4'b1111, 1, 4'b1000, 1, 16, 3);
    addVec(0, 4'b1111, 1, 4'b0001, 1, 1, 0);
    addVec(0, 4'b1111, 1, 4'b0010, 1, 4, 1);
    addVec(0, 4'b1010, 1, 4'b1000, 1, 16, 3);
    addVec(0, 4'b1010, 1, 4'b0010, 1, 4, 1);
    addVec(0, 4'b1010, 1, 4'b1000, 1, 16, 3);
`else
    addVec(0, 4'b1111, 1, 4'b0001, 1, 1, 0);
    addVec(0, 4'b1111, 1, 4'b0001, 1, 1, 0);
    addVec(0, 4'b1111, 1, 4'b0001, 1, 1, 0);
    addVec(0, 4'b1111, 1, 4'b0001, 1, 1, 0);
    addVec(0, 4'b1111, 1, 4'b0001, 1, 1, 0);
    addVec(0, 4'b1111, 1, 4'b0001, 1, 1, 0);
    addVec(0, 4'b1010, 1, 4'b0010, 1, 4, 1);
    addVec(0, 4'b1010, 1, 4'b0010, 1, 4, 1);
    addVec(0, 4'b1010, 1, 4'b0010, 1, 4, 1);
`endif
    // Backpressure: load ch1 (data 4), stall three cycles, then release
    addVec(0, 4'b0010, 1, 4'b0010, 1, 4, 1);
    addVec(0, 4'b1111, 0, 4'b0000, 1, 4, 1);
    addVec(0, 4'b1111, 0, 4'b0000, 1, 4, 1);
    addVec(0, 4'b1111, 0, 4'b0000, 1, 4, 1);
`ifdef MUX_ARB_ROUND_ROBIN_EN
    addVec(0, 4'b1111, 1, 4'b0100, 1, 9, 2);
`else
    addVec(0, 4'b1111, 1, 4'b0001, 1, 1, 0);
`endif
    // Reset mid-stream after the third saturated grant
    addVec(1, 4'b0000, 1, 4'b0000, 0, 0, 0);
`ifdef MUX_ARB_ROUND_ROBIN_EN
    addVec(0, 4'b1111, 1, 4'b0001, 1, 1, 0);
    addVec(0, 4'b1111, 1, 4'b0010, 1, 4, 1);
    addVec(0, 4'b1111, 1, 4'b0100, 1, 9, 2);
`else
    addVec(0, 4'b1111, 1, 4'b0001, 1, 1, 0);
    addVec(0, 4'b1111, 1, 4'b0001, 1, 1, 0);
    addVec(0, 4'b1111, 1, 4'b0001, 1, 1, 0);
`endif
    addVec(1, 4'b1111, 1, 4'b0000, 0, 0, 0);
    addVec(0, 4'b1111, 1, 4'b0001, 1, 1, 0);
    // Hold with no consumer, drain, then load into an empty register while out_ready is low
    addVec(0, 4'b0000, 0, 4'b0000, 1, 1, 0);
    addVec(0, 4'b0000, 1, 4'b0000, 0, 1, 0);
    addVec(0, 4'b0100, 0, 4'b0100, 1, 9, 2);
    addVec(0, 4'b0100, 0, 4'b0000, 1, 9, 2);

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i], i);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mux_arbiter.md
# mux_arbiter

Parametrised, registered M-to-1 multiplexer with per-channel valid/ready handshakes. It generalises the fixed combinational mux2–mux32 family: channel count and data width are parameters. Selection is arbitrated internally rather than driven by an external select. One output register stage sits between the arbiter and the consumer. It is used wherever several producers share one downstream port, such as memory request merging or bus write-back.

## Interface
- `N`, default 32: data width per channel, ≥1.
- `M`, default 4: channel count, ≥2. `S = $clog2(M)` is the select width.
- `clk` input, 1 bit: single clock; all state updates on the rising edge.
- `rst` input, 1 bit: reset, synchronous and active-high.
- `in_data` input, M*N bits: channel i occupies `in_data[i*N +: N]`.
- `in_valid` input, M bits: channel i offers a word.
- `in_ready` output, M bits: channel i's word is taken this cycle. Combinational. At most one bit is set.
- `out_data` output, N bits: registered selected word.
- `out_valid` output, 1 bit: `out_data` holds a word.
- `out_ready` input, 1 bit: consumer accepts the word this cycle.
- `out_sel` output, S bits: index of the channel that supplied `out_data`. Registered.

## Operation
- Handshakes:
  - Input transfer on channel i occurs when `in_valid[i] && in_ready[i]`.
  - Output transfer occurs when `out_valid && out_ready`.
- Load enable: `load = !out_valid || out_ready`. The output register is empty, or is draining this cycle.
- Arbitration is combinational over `in_valid` and uses priority pointer `ptr` (S bits).
  - The grant goes to the first valid channel scanning from `ptr` upward, wrapping from M-1 to 0.
  - If no channel is valid, there is no grant.
- `in_ready[g] = load` for the granted channel g. All other bits are 0.
- On an input transfer:
  - `out_data <= word g`, `out_sel <= g`, `out_valid <= 1`.
  - `ptr <= (g+1) mod M`. When M is not a power of 2, the wrap is explicit, never by truncation.
- On an output transfer with no simultaneous input transfer: `out_valid <= 0`. `out_data` and `out_sel` hold their last values.
- Simultaneous output and input transfer: the register is overwritten with the new word and `out_valid` stays 1. This gives full throughput of one word per cycle.
- `ptr` changes only on an input transfer. A grant that is not taken because of backpressure does not advance fairness.
- No lock or hold: the grant is recomputed every cycle. A requester that drops `in_valid` before transfer is simply skipped.
- `in_data` of non-granted channels is ignored. There is no X-propagation from idle channels to `out_data`.

## Timing
- Reset values: `out_valid=0`, `out_data=0`, `out_sel=0`, `ptr=0`.
  - `in_ready` is combinational, so it is 0 while `rst=1`, because `rst` gates the load.
- Latency: a word accepted on edge k appears on `out_data` with `out_valid=1` after edge k. That is one cycle.
- Throughput: one word per cycle while `out_ready=1` and any `in_valid` is set.
- Backpressure:
  - While `out_valid=1 && out_ready=0`: `out_data`, `out_sel` and `out_valid` are stable, and all `in_ready` are 0.
- Reset mid-operation: `rst=1` at any edge discards the held word and forces the reset values, regardless of the handshakes in that cycle.
- Combinational paths:
  - `out_ready` → `in_ready`.
  - `in_valid` → `in_ready`.
  - No path from `in_data` to any output.

## Configuration
- `MUX_ARB_ROUND_ROBIN_EN` defined: round-robin arbitration as above. `ptr` exists and advances on each input transfer.
- `MUX_ARB_ROUND_ROBIN_EN` undefined: fixed priority, where the lowest valid index always wins.
  - `ptr` is removed and the scan is equivalent to `ptr=0`.
  - All other behaviour and timing are identical.

## Test plan
Common setup: M=4, N=32, channel data ch0=1, ch1=4, ch2=9, ch3=16.
- Reset: hold `rst=1` for 2 cycles with `in_valid=4'b1111`. Required: `out_valid=0`, `out_data=0`, `out_sel=0`, `in_ready=0` throughout.
- Single channel: `in_valid=4'b0100`, `out_ready=1`. Required: `in_ready=4'b0100` that cycle. Next cycle `out_valid=1`, `out_data=9`, `out_sel=2`.
- Saturated fairness: `in_valid=4'b1111` held, `out_ready=1`.
  - With the macro: `out_sel` sequence 0,1,2,3,0 and `out_data` 1,4,9,16,1.
  - Without the macro: `out_sel` is 0 every cycle and `out_data` is 1.
- Skip and wrap: after a grant to ch1, set `in_valid=4'b1010`. Required grants are 3, then 1, then 3 (with the macro).
- Backpressure: `out_valid=1` with `out_data=4`, then `out_ready=0` for 3 cycles.
  - Required while stalled: `out_data=4` is stable and `in_ready=0`.
  - On the cycle `out_ready` returns to 1: a new word is accepted in the same cycle, and `out_valid` stays 1 on the next cycle.
- Reset mid-stream: assert `rst` for 1 cycle during the saturated sequence, just after `out_sel=2`.
  - Required: the next cycle shows `out_valid=0`.
  - After release, the first grant is ch0 (`out_data=1`).
